// File: rtl/fetch_unit.sv
// Fetch unit for the multi-cycle MIPS core: PC, next-PC mux, IR and the imem fetch handshake.
// Optional build macro FETCH_ALIGN_CHECK_EN: suppress misaligned PC writes and raise addr_err.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcwr,
    input  logic        irwr,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] rs_data,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic        if_stall,
    output logic        addr_err
);

    // imem handshake: imem_req stays high from the cycle after irwr until the edge where
    // imem_ack is sampled high; imem_addr is constant over that window.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_fetch_addr;

    logic [31:0] w_npc;
    logic [31:0] w_br_off;
    logic        w_npc_ok;
    logic        w_fetch_start;
    logic        w_pc_write;

    always_comb begin
        w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
        w_npc    = r_pc + 32'd4;
        case (npc_sel)
            2'b00:   w_npc = r_pc + 32'd4;
            2'b01:   w_npc = r_pc + w_br_off;
            2'b10:   w_npc = {r_pc[31:28], r_ir[25:0], 2'b00};
            default: w_npc = rs_data;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_addr_err;
    logic w_addr_fault;

    assign w_npc_ok      = (w_npc[1:0] == 2'b00);
    assign w_fetch_start = irwr && !r_addr_err;
    assign w_addr_fault  = (r_state == S_IDLE) && pcwr && !w_fetch_start && !w_npc_ok;

    // Sticky until reset; once set, no further fetch can be started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else if (w_addr_fault) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err  = r_addr_err;
    assign imem_addr = r_fetch_addr;
`else
    assign w_npc_ok      = 1'b1;
    assign w_fetch_start = irwr;
    assign addr_err      = 1'b0;
    assign imem_addr     = {r_fetch_addr[31:2], 2'b00};
`endif

    // A pcwr coinciding with irwr is dropped: the fetch completion does the +4 instead.
    assign w_pc_write = (r_state == S_IDLE) && pcwr && !w_fetch_start && w_npc_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_ir         <= 32'd0;
            r_fetch_addr <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fetch_start) begin
                        r_fetch_addr <= r_pc;
                        r_state      <= S_FETCH;
                    end else if (w_pc_write) begin
                        r_pc <= w_npc;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= r_fetch_addr + 32'd4;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // if_stall doubles as the observable FSM state (1 = FETCH).
    assign if_stall = (r_state == S_FETCH);
    assign imem_req = (r_state == S_FETCH);
    assign ir       = r_ir;
    assign opcode   = r_ir[31:26];
    assign funct    = r_ir[5:0];
    assign pc       = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a PC/IR reference model.
// Also exercises FETCH_ALIGN_CHECK_EN behaviour when that macro is defined.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        pcwr;
    logic        irwr;
    logic [1:0]  npc_sel;
    logic [31:0] rs_data;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic        if_stall;
    logic        addr_err;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcwr       (pcwr),
        .irwr       (irwr),
        .npc_sel    (npc_sel),
        .rs_data    (rs_data),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .ir         (ir),
        .opcode     (opcode),
        .funct      (funct),
        .pc         (pc),
        .if_stall   (if_stall),
        .addr_err   (addr_err)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];       // {ir, pc} expected at fetch completion
    int          exp_w_q[$];     // expected number of stall cycles
    logic [31:0] exp_addr_q[$];  // expected imem_addr for each issued fetch

    logic [31:0] pc_m;
    logic [31:0] ir_m;
    logic        addr_err_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_npc(input logic [1:0] sel, input logic [31:0] cur_pc,
                                              input logic [31:0] cur_ir, input logic [31:0] rs);
        int          off;
        logic [31:0] tgt;
        off = int'($signed(cur_ir[15:0]));
        tgt = {6'd0, cur_ir[25:0]};
        case (sel)
            2'd0:    return cur_pc + 32'd4;
            2'd1:    return cur_pc + 32'(off * 4);
            2'd2:    return (cur_pc & 32'hF000_0000) | (tgt * 32'd4);
            default: return rs;
        endcase
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] data, input int w, input bit same_pcwr,
                            input bit mid_pulse);
        logic [31:0] fa;
        fa = pc_m;
        exp_addr_q.push_back(model_addr(fa));
        irwr    = 1'b1;
        pcwr    = same_pcwr;
        npc_sel = 2'($urandom_range(0, 3));
        rs_data = $urandom;
        tick();
        irwr = 1'b0;
        pcwr = 1'b0;
        for (int i = 1; i < w; i++) begin
            if (mid_pulse && i == 1) begin
                irwr    = 1'b1;
                pcwr    = 1'b1;
                npc_sel = 2'($urandom_range(0, 3));
            end
            tick();
            irwr = 1'b0;
            pcwr = 1'b0;
            check("pc_during_stall", pc, fa);
            check("ir_during_stall", ir, ir_m);
        end
        pc_m = fa + 32'd4;
        ir_m = data;
        exp_q.push_back({data, fa + 32'd4});
        exp_w_q.push_back(w);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic do_pcwr(input logic [1:0] sel, input logic [31:0] rs);
        logic [31:0] npc;
        npc     = model_npc(sel, pc_m, ir_m, rs);
        pcwr    = 1'b1;
        npc_sel = sel;
        rs_data = rs;
        tick();
        pcwr = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (npc[1:0] != 2'b00) addr_err_m = 1'b1;
        else pc_m = npc;
`else
        pc_m = npc;
`endif
        check("pc_after_pcwr", pc, pc_m);
        check("addr_err_after_pcwr", 32'(addr_err), 32'(addr_err_m));
    endtask

    task automatic idle_ack();
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        tick();
        imem_ack = 1'b0;
        check("idle_ack_ir", ir, ir_m);
        check("idle_ack_pc", pc, pc_m);
        check("idle_ack_stall", 32'(if_stall), 32'd0);
    endtask

    // ---------------- monitor ----------------
    logic        prev_req;
    logic        prev_stall;
    int          stall_cnt;
    logic [31:0] held_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_stall = 1'b0;
            stall_cnt  = 0;
        end else begin
            check("stall_eq_req", 32'(if_stall), 32'(imem_req));
            if (imem_req && !prev_req) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                    held_addr = imem_addr;
                end else begin
                    held_addr = exp_addr_q.pop_front();
                    check("imem_addr", imem_addr, held_addr);
                end
            end else if (imem_req) begin
                check("imem_addr_held", imem_addr, held_addr);
            end
            if (if_stall) stall_cnt++;
            if (!if_stall && prev_stall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fetch_done", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    int          ew;
                    e  = exp_q.pop_front();
                    ew = exp_w_q.pop_front();
                    check("fetch_ir", ir, e[63:32]);
                    check("fetch_pc", pc, e[31:0]);
                    check("fetch_opcode", 32'(opcode), 32'(e[63:58]));
                    check("fetch_funct", 32'(funct), 32'(e[37:32]));
                    check("stall_cycles", 32'(stall_cnt), 32'(ew));
                end
                stall_cnt = 0;
            end
            prev_req   = imem_req;
            prev_stall = if_stall;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b1;
        pcwr       = 1'b0;
        irwr       = 1'b0;
        npc_sel    = 2'b00;
        rs_data    = 32'd0;
        imem_rdata = 32'd0;
        imem_ack   = 1'b0;
        pc_m       = RESET_PC;
        ir_m       = 32'd0;
        addr_err_m = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, RESET_PC);
        check("rst_ir", ir, 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_funct", 32'(funct), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_if_stall", 32'(if_stall), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic fetch, ack in first FETCH cycle
        do_fetch(32'h3C01_1234, 1, 1'b0, 1'b0);
        check("lui_opcode", 32'(opcode), 32'h0F);
        check("lui_pc", pc, 32'h0000_3004);

        // stretched fetch with a stray irwr/pcwr mid-stall
        do_fetch($urandom, 3, 1'b1, 1'b1);
        check("stretch_pc", pc, 32'h0000_3008);

        // beq with imm -2 from pc 0x3008
        do_pcwr(2'b11, 32'h0000_3004);
        do_fetch(32'h1000_FFFE, 1, 1'b0, 1'b0);
        do_pcwr(2'b01, 32'd0);
        check("beq_target", pc, 32'h0000_3000);

        // jal and jr from pc 0x3010
        do_pcwr(2'b11, 32'h0000_300C);
        do_fetch(32'h0C00_0C10, 2, 1'b0, 1'b0);
        do_pcwr(2'b10, 32'd0);
        check("jal_target", pc, 32'h0000_3040);
        do_pcwr(2'b11, 32'h0000_3100);
        check("jr_target", pc, 32'h0000_3100);

        // modulo wrap of the fetch increment
        do_pcwr(2'b11, 32'hFFFF_FFFC);
        do_fetch($urandom, 1, 1'b0, 1'b0);
        check("wrap_pc", pc, 32'h0000_0000);

        idle_ack();

        // randomized mix
        do_pcwr(2'b11, RESET_PC);
        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                do_fetch($urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            end else if (r <= 8) begin
                do_pcwr(2'($urandom_range(0, 3)), RESET_PC + 32'($urandom_range(0, 255) * 4));
            end else begin
                idle_ack();
            end
        end

        // reset in the middle of a fetch
        exp_addr_q.push_back(model_addr(pc_m));
        irwr = 1'b1;
        tick();
        irwr = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        pc_m = RESET_PC;
        ir_m = 32'd0;
        check("abort_imem_req", 32'(imem_req), 32'd0);
        check("abort_if_stall", 32'(if_stall), 32'd0);
        check("abort_pc", pc, RESET_PC);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        idle_ack();
        check("late_ack_ir", ir, 32'd0);

        // misaligned jr target
        do_pcwr(2'b11, 32'h0000_3102);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign_pc_held", pc, RESET_PC);
        check("misalign_addr_err", 32'(addr_err), 32'd1);
        irwr = 1'b1;
        tick();
        irwr = 1'b0;
        check("blocked_req", 32'(imem_req), 32'd0);
        tick();
        check("blocked_req_2", 32'(imem_req), 32'd0);
`else
        check("misalign_pc_written", pc, 32'h0000_3102);
        do_fetch($urandom, 2, 1'b0, 1'b0);
        check("misalign_next_pc", pc, 32'h0000_3106);
`endif

        tick();
        tick();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("exp_addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
